// File: rtl/watch_fnd_display.sv
// ---------------------------------------------------------------------------
// watch_fnd_display: binary hour/min to BCD, 4-digit multiplexed FND drive
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module watch_fnd_display #(
  parameter int unsigned SCAN_DIV  = 100_000,
  parameter int unsigned BLINK_DIV = 50_000_000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] hour,
  input  logic [7:0] min,
  input  logic       set_mode,
  output logic [3:0] com,
  output logic [7:0] seg_7
);

  localparam int unsigned SCAN_W  = (SCAN_DIV  > 1) ? $clog2(SCAN_DIV)  : 1;
  localparam int unsigned BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [SCAN_W-1:0]  SCAN_LAST  = SCAN_W'(SCAN_DIV - 1);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_SHIFT = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  function automatic logic [11:0] add3(input logic [11:0] b);
    logic [11:0] r;
    r = b;
    for (int i = 0; i < 3; i++) begin
      if (b[4*i +: 4] >= 4'd5) r[4*i +: 4] = b[4*i +: 4] + 4'd3;
    end
    return r;
  endfunction

  // Any nonzero hundreds digit means the value is out of the 0..99 range.
  function automatic logic [7:0] to_nibs(input logic [11:0] bcd);
    return (bcd[11:8] != 4'd0) ? 8'hFF : bcd[7:0];
  endfunction

  function automatic logic [6:0] seg_decode(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      4'hF:    s = 7'b0111111;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  logic [SCAN_W-1:0]  scan_cnt_q, scan_cnt_d;
  logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
  logic [1:0]         digit_idx_q, digit_idx_d;
  logic               blink_phase_q, blink_phase_d;
  logic               scan_wrap, blink_wrap, frame_start;

  assign scan_wrap   = (scan_cnt_q == SCAN_LAST);
  assign blink_wrap  = (blink_cnt_q == BLINK_LAST);
  assign frame_start = scan_wrap && (digit_idx_q == 2'd3);

  always_comb begin
    scan_cnt_d    = scan_wrap  ? '0 : scan_cnt_q + 1'b1;
    blink_cnt_d   = blink_wrap ? '0 : blink_cnt_q + 1'b1;
    digit_idx_d   = scan_wrap  ? digit_idx_q + 2'd1 : digit_idx_q;
    blink_phase_d = blink_wrap ? ~blink_phase_q : blink_phase_q;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      scan_cnt_q    <= '0;
      blink_cnt_q   <= '0;
      digit_idx_q   <= 2'd0;
      blink_phase_q <= 1'b0;
    end else begin
      scan_cnt_q    <= scan_cnt_d;
      blink_cnt_q   <= blink_cnt_d;
      digit_idx_q   <= digit_idx_d;
      blink_phase_q <= blink_phase_d;
    end
  end

  state_e      state_q;
  logic        first_q;
  logic [2:0]  iter_q;
  logic [7:0]  hr_bin_q, mn_bin_q;
  logic [11:0] hr_bcd_q, mn_bcd_q;
  logic [3:0]  nib_q [4];
  logic [11:0] hr_adj, mn_adj;
  logic [19:0] hr_sh, mn_sh;
  logic [7:0]  hr_nibs, mn_nibs;

  assign hr_adj  = add3(hr_bcd_q);
  assign mn_adj  = add3(mn_bcd_q);
  assign hr_sh   = {hr_adj, hr_bin_q} << 1;
  assign mn_sh   = {mn_adj, mn_bin_q} << 1;
  assign hr_nibs = to_nibs(hr_bcd_q);
  assign mn_nibs = to_nibs(mn_bcd_q);

  // Conversion runs on shadow copies; nib_q only changes in DONE so a frame
  // never mixes digits from two different snapshots.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      first_q  <= 1'b1;
      iter_q   <= 3'd0;
      hr_bin_q <= 8'd0;
      mn_bin_q <= 8'd0;
      hr_bcd_q <= 12'd0;
      mn_bcd_q <= 12'd0;
      for (int i = 0; i < 4; i++) nib_q[i] <= 4'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (first_q || frame_start) begin
            state_q <= S_LOAD;
            first_q <= 1'b0;
          end
        end
        S_LOAD: begin
          hr_bin_q <= hour;
          mn_bin_q <= min;
          hr_bcd_q <= 12'd0;
          mn_bcd_q <= 12'd0;
          iter_q   <= 3'd0;
          state_q  <= S_SHIFT;
        end
        S_SHIFT: begin
          hr_bcd_q <= hr_sh[19:8];
          hr_bin_q <= hr_sh[7:0];
          mn_bcd_q <= mn_sh[19:8];
          mn_bin_q <= mn_sh[7:0];
          iter_q   <= iter_q + 3'd1;
          if (iter_q == 3'd7) state_q <= S_DONE;
        end
        S_DONE: begin
          nib_q[0] <= mn_nibs[3:0];
          nib_q[1] <= mn_nibs[7:4];
          nib_q[2] <= hr_nibs[3:0];
          nib_q[3] <= hr_nibs[7:4];
          state_q  <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // The slot latched at each scan wrap is the one digit_idx is leaving, so
  // com and seg_7 always come from the same slot on the same edge.
  logic       active_q, active_d;
  logic [1:0] slot_q, slot_d;
  logic [3:0] com_q, com_d;
  logic [7:0] seg_q;

  always_comb begin
    active_d = active_q | scan_wrap;
    slot_d   = scan_wrap ? digit_idx_q : slot_q;
    if (!active_d)                       com_d = 4'b1111;
    else if (set_mode && !blink_phase_d) com_d = 4'b1111;
    else                                 com_d = ~(4'b0001 << slot_d);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      active_q <= 1'b0;
      slot_q   <= 2'd0;
      com_q    <= 4'b1111;
      seg_q    <= 8'hFF;
    end else begin
      active_q <= active_d;
      slot_q   <= slot_d;
      com_q    <= com_d;
      if (scan_wrap) begin
        seg_q <= {~((digit_idx_q == 2'd2) && blink_phase_d),
                  seg_decode(nib_q[digit_idx_q])};
      end
    end
  end

  assign com   = com_q;
  assign seg_7 = seg_q;

endmodule

`default_nettype wire

// File: doc/watch_fnd_display.md
# watch_fnd_display

Display-side consumer of the watch core's binary time outputs. Takes `hour` (0–23) and `min` (0–59) as 8-bit binary values, converts them to BCD with a sequential shift-add-3 engine, and drives a 4-digit common-anode 7-segment (FND) display through a time-multiplexed scan. It provides a blinking colon and a set-mode blink of all digits. It sits between the watch core and the board's FND pins.

## Interface
- `SCAN_DIV`, 100_000: clk cycles per digit slot (1 ms at 100 MHz).
- `BLINK_DIV`, 50_000_000: clk cycles per blink phase toggle (0.5 s at 100 MHz).
- `clk` input, 1 bit: system clock; all logic on its rising edge.
- `reset_n` input, 1 bit: synchronous, active-low reset.
- `hour` input, 8 bits: binary hours from the watch core.
- `min` input, 8 bits: binary minutes from the watch core.
- `set_mode` input, 1 bit: when 1, all digits blink with the blink phase.
- `com` output, 4 bits: digit enables, active-low. Bit 3 is hour tens, bit 2 hour units, bit 1 min tens, bit 0 min units.
- `seg_7` output, 8 bits: segments `{dp,g,f,e,d,c,b,a}`, active-low (0 = lit).

## Operation
- **Scan counter:** `scan_cnt` counts 0..SCAN_DIV-1. When it wraps, `digit_idx` (2 bits) advances 0→1→2→3→0. `digit_idx` 0 selects `com[0]`, and so on up to 3 selecting `com[3]`. Exactly one `com` bit is low at any time after the first slot.
- **Blink counter:** `blink_cnt` counts 0..BLINK_DIV-1. `blink_phase` toggles on each wrap.
- **Conversion FSM:** states IDLE, LOAD, SHIFT, DONE.
  - IDLE→LOAD on the cycle `digit_idx` wraps 3→0 (frame start), and also on the first cycle after reset release.
  - LOAD: snapshot `hour` and `min` into shadow registers; clear the BCD scratch. Next state is SHIFT.
  - SHIFT: 8 iterations. In each, add 3 to every BCD nibble ≥5 of both operands, then shift left by 1 with the next binary MSB. After 8 iterations, go to DONE.
  - DONE: latch all four display nibbles atomically, then return to IDLE.
  - Mid-frame input changes are not shown until the next frame's DONE.
- **Range rule:** a snapshot value ≥100 latches tens and units both as code 4'hF, which renders as a dash (segment g only). Values 0–99 display normally. Leading zeros are shown: 07:05, not " 7:05".
- **Decoder:** 0–9 use the standard active-low patterns (0→7'b1000000, 1→7'b1111001, … 9→7'b0010000). 4'hF→7'b0111111. Codes A–E never occur; if they do, the digit is blank (7'b1111111).
- **Colon:** `dp` is lit only on the hour-units slot (`digit_idx`=2) and only when `blink_phase`=1. It is unlit on all other digits.
- **Set-mode blink:** when `set_mode`=1 and `blink_phase`=0, `com` is 4'b1111. Scanning and conversion continue unaffected.

## Timing
- Reset (`reset_n`=0 at a rising edge) clears the following, all on the same edge:
  - `scan_cnt`, `blink_cnt`, `digit_idx`=0, `blink_phase`=0.
  - FSM to IDLE.
  - All display nibbles to 0.
  - `com`=4'b1111, `seg_7`=8'hFF.
- Reset asserted mid-conversion abandons the conversion; display nibbles are not updated from partial data.
- `com` and `seg_7` are registered and change on the same edge as `digit_idx`. No cycle exists in which the new `com` is paired with the old digit's segments.
- Conversion latency: 1 cycle for LOAD, 8 for SHIFT, 1 for DONE. Display nibbles are valid 10 cycles after the trigger. SCAN_DIV ≥ 16 is required, so conversion always finishes within slot 0.
- First valid digit is driven at the first `digit_idx` advance after reset, i.e. SCAN_DIV cycles after release. `com` stays 4'b1111 until then.
- Frame period is 4×SCAN_DIV cycles. Blink period is 2×BLINK_DIV cycles.
- `set_mode` is sampled every cycle. It takes effect on the next registered `com` update; there is no debounce.

## Test plan
- **Reset:** hold `reset_n`=0 for 5 cycles with `hour`=12, `min`=34 → `com`=4'b1111, `seg_7`=8'hFF. After release (SCAN_DIV=16), after 16 cycles `com`=4'b1110 and `seg_7[6:0]`=7'b0011001 (digit "4").
- **Full frame:** `hour`=23, `min`=59, SCAN_DIV=16 → slots show 9, 5, 3, 2 on `com` 1110, 1101, 1011, 0111. `dp` is low only on slot 2 while `blink_phase`=1.
- **Conversion latency:** change `min` 00→45 mid-frame → the display still shows 00 until frame start. DONE asserts exactly 10 cycles after the 3→0 wrap, and the digits then read 4 and 5.
- **Out of range:** `min`=8'd120 → both minute digits show 7'b0111111 (dashes). Hour digits are unaffected.
- **Set-mode blink:** `set_mode`=1 with BLINK_DIV=64 → `com` is 4'b1111 for 64 cycles, then resumes scanning for 64 cycles, repeating. Setting `set_mode`=0 restores continuous scan.
- **Reset mid-SHIFT:** assert `reset_n`=0 at SHIFT iteration 4 → FSM is in IDLE and nibbles are 0 the next cycle. After release, a fresh LOAD of the current inputs completes within 10 cycles.
